// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N:1 streaming multiplexer with valid/ready handshakes,
// a single registered output stage, an accepted-transfer counter and a
// runtime choice between fixed channel select and round-robin arbitration.
module stream_mux_arb #(
  parameter  int N     = 4,
  parameter  int W     = 8,
  parameter  int CNT_W = 16,
  localparam int SW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_ch,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  logic [SW-1:0]    r_out_ch;
  logic [CNT_W-1:0] r_xfer_cnt;
  logic [SW-1:0]    r_rr_ptr;

  logic             w_load;
  logic             w_grant_any;
  logic [SW-1:0]    w_grant_idx;
  logic [W-1:0]     w_grant_data;
  logic             w_xfer;

  // The output register can take a new word when it is empty or draining now.
  assign w_load = !r_out_valid || out_ready;

  // Pick the granted channel: fixed select, or the first valid channel at or
  // after the round-robin pointer (wrapping). The round-robin scan runs from
  // the farthest offset to the nearest so the nearest valid channel wins.
  always_comb begin : p_grant
    int v_idx;
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_grant_any  = 1'b0;
    w_grant_idx  = '0;
    w_grant_data = '0;
    v_idx        = 0;
    if (!mode) begin
      if (int'(sel) < N) begin
        if (in_valid[sel]) begin
          w_grant_any = 1'b1;
          w_grant_idx = sel;
        end
      end
    end else begin
      for (int off = N - 1; off >= 0; off--) begin
        v_idx = int'(r_rr_ptr) + off;
        if (v_idx >= N) v_idx = v_idx - N;
        if (in_valid[v_idx]) begin
          w_grant_any = 1'b1;
          w_grant_idx = SW'(v_idx);
        end
      end
    end
    w_grant_data = in_data[int'(w_grant_idx)*W +: W];
  end

  // A transfer happens when a granted channel meets a free output register
  // outside of reset; grant already implies the channel's valid is set.
  assign w_xfer = rst_n && w_load && w_grant_any;

  // Raise ready only on the channel that actually transfers this cycle.
  always_comb begin
    in_ready = '0;
    if (w_xfer) in_ready[w_grant_idx] = 1'b1;
  end

  // Output stage, transfer counter and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_xfer_cnt  <= '0;
      r_rr_ptr    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_grant_data;
      r_out_ch    <= w_grant_idx;
      r_xfer_cnt  <= r_xfer_cnt + 1'b1;
      if (mode) begin
        r_rr_ptr <= (w_grant_idx == SW'(N - 1)) ? '0 : w_grant_idx + 1'b1;
      end
    end else if (out_ready) begin
      // Drained with nothing to reload; data and channel keep their values.
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: scoreboard bench for stream_mux_arb. A 4-channel
// instance gets directed and random traffic checked against a behavioural
// model; a 6-channel, 2-bit-counter instance covers select-range and
// counter-wrap corners.
module tb_stream_mux_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] ch;
  } word_t;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel instance
  logic           rst_n = 1'b0;
  logic           mode = 1'b0;
  logic [SW-1:0]  sel = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_ready = 1'b1;
  logic [15:0]    xfer_cnt;

  stream_mux_arb #(.N(N), .W(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  // 6-channel instance with a 2-bit counter
  logic        rst6_n = 1'b0;
  logic        mode6 = 1'b0;
  logic [2:0]  sel6 = '0;
  logic [5:0]  in_valid6 = '0;
  logic [47:0] in_data6 = {8'h55, 8'h54, 8'h53, 8'h52, 8'h51, 8'h50};
  logic [5:0]  in_ready6;
  logic        out_valid6;
  logic [7:0]  out_data6;
  logic [2:0]  out_ch6;
  logic        out_ready6 = 1'b1;
  logic [1:0]  xfer_cnt6;

  stream_mux_arb #(.N(6), .W(8), .CNT_W(2)) dut6 (
    .clk(clk), .rst_n(rst6_n), .mode(mode6), .sel(sel6),
    .in_valid(in_valid6), .in_data(in_data6), .in_ready(in_ready6),
    .out_valid(out_valid6), .out_data(out_data6), .out_ch(out_ch6),
    .out_ready(out_ready6), .xfer_cnt(xfer_cnt6)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  word_t sb[$];
  int    m_rr = 0;
  int    m_cnt = 0;
  bit    was_reset = 1'b0;

  // Winner of the cycle from the rules: fixed mode takes sel if valid;
  // round-robin takes the valid channel with the smallest forward distance
  // from the pointer. Returns -1 when nothing is granted.
  function automatic int model_grant(input logic md, input int sl,
                                     input logic [N-1:0] v, input int ptr);
    int best, best_d, d;
    if (!md) return (sl < N && v[sl]) ? sl : -1;
    best   = -1;
    best_d = N;
    for (int c = 0; c < N; c++) begin
      if (v[c]) begin
        d = (c - ptr + N) % N;
        if (d < best_d) begin
          best_d = d;
          best   = c;
        end
      end
    end
    return best;
  endfunction

  // One stimulus cycle: drive after the falling edge, check the handshake
  // side against the model, and queue the word the next edge will load.
  task automatic cycle(input logic r, input logic md, input logic [SW-1:0] s,
                       input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic ordy);
    int         g;
    logic [N-1:0] e;
    word_t      w;
    @(negedge clk);
    #1;
    rst_n = r; mode = md; sel = s; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    g = model_grant(md, int'(s), v, m_rr);
    e = '0;
    if (r && (sb.size() == 0 || ordy) && g >= 0) e[g] = 1'b1;
    check("in_ready", in_ready, e);
    if (was_reset) begin
      check("out_valid", out_valid, sb.size() != 0);
      check("xfer_cnt", xfer_cnt, m_cnt % 65536);
    end
    if (!r) begin
      sb.delete();
      m_cnt     = 0;
      m_rr      = 0;
      was_reset = 1'b1;
    end else if (e != '0) begin
      w.data = d[g*W +: W];
      w.ch   = SW'(g);
      sb.push_back(w);
      m_cnt++;
      if (md) m_rr = (g + 1) % N;
    end
  endtask

  // Monitor: compare the presented word with the scoreboard head; it stays
  // at the head (and must stay stable) until the downstream accepts it.
  initial begin
    word_t h;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n === 1'b1 && was_reset && out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out_word: got ch %0d data %0h expected no word at %0t",
                   out_ch, out_data, $time);
        end else begin
          h = sb[0];
          check("out_data", out_data, h.data);
          check("out_ch", out_ch, h.ch);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic c6(input logic r, input logic md, input logic [2:0] s,
                    input logic [5:0] v, input logic ordy);
    @(negedge clk);
    #1;
    rst6_n = r; mode6 = md; sel6 = s; in_valid6 = v; out_ready6 = ordy;
    #1;
  endtask

  initial begin
    logic        rmode;
    logic [31:0] rd;

    // Reset with every channel valid
    cycle(0, 0, 0, 4'b1111, 32'h0, 1);
    cycle(0, 0, 0, 4'b1111, 32'h0, 1);

    // Fixed select of channel 2
    cycle(1, 0, 2, 4'b1111, 32'h11A5_2233, 1);
    cycle(1, 0, 2, 4'b0000, 32'h0, 1);
    cycle(1, 0, 2, 4'b0000, 32'h0, 1);

    // Round robin, all valid, six cycles from a fresh pointer
    cycle(0, 1, 0, 4'b0000, 32'h0, 1);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 4'b1111, 32'h4433_2211 + i, 1);
    cycle(1, 1, 0, 4'b0000, 32'h0, 1);
    check("rr_xfer_cnt", xfer_cnt, 6);

    // Sparse round robin over channels 1 and 3
    cycle(0, 1, 0, 4'b0000, 32'h0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 4'b1010, 32'hD0C0_B0A0 + i, 1);
    cycle(1, 1, 0, 4'b0000, 32'h0, 1);

    // Backpressure on a held 0x3C, then release with a word waiting
    cycle(1, 0, 0, 4'b0001, 32'h0000_003C, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 4'b1111, 32'h7777_7777, 0);
    cycle(1, 0, 0, 4'b1111, 32'h0000_0099, 1);
    cycle(1, 0, 0, 4'b0000, 32'h0, 1);

    // Randomised traffic with mode switches, backpressure and rare resets
    rmode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rmode = ~rmode;
      rd = $urandom;
      cycle($urandom_range(0, 199) != 0, rmode, SW'($urandom_range(0, N - 1)),
            N'($urandom), rd, $urandom_range(0, 3) != 0);
    end
    cycle(1, 0, 0, 4'b0000, 32'h0, 1);
    cycle(1, 0, 0, 4'b0000, 32'h0, 1);

    // Six-channel corners
    c6(0, 0, 0, 6'h3F, 1);
    check("n6_reset_ready", in_ready6, 6'b000000);
    c6(1, 0, 5, 6'h3F, 1);
    check("n6_sel5_ready", in_ready6, 6'b100000);
    c6(1, 0, 6, 6'h3F, 1);
    check("n6_sel6_ready", in_ready6, 6'b000000);
    check("n6_sel5_valid", out_valid6, 1);
    check("n6_sel5_data", out_data6, 8'h55);
    check("n6_sel5_ch", out_ch6, 5);
    check("n6_cnt1", xfer_cnt6, 1);
    c6(1, 0, 7, 6'h3F, 1);
    check("n6_sel7_ready", in_ready6, 6'b000000);
    check("n6_drained", out_valid6, 0);
    check("n6_cnt_hold", xfer_cnt6, 1);
    c6(1, 0, 0, 6'h3F, 1);
    check("n6_sel0_ready", in_ready6, 6'b000001);
    c6(1, 0, 0, 6'h3F, 1);
    check("n6_cnt2", xfer_cnt6, 2);
    c6(1, 0, 0, 6'h3F, 1);
    check("n6_cnt3", xfer_cnt6, 3);
    c6(1, 0, 0, 6'h00, 0);
    check("n6_cnt_wrap", xfer_cnt6, 0);
    check("n6_held_valid", out_valid6, 1);
    c6(0, 0, 0, 6'h3F, 1);
    check("n6_rst_ready", in_ready6, 6'b000000);
    c6(1, 0, 0, 6'h00, 1);
    check("n6_rst_valid", out_valid6, 0);
    check("n6_rst_cnt", xfer_cnt6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
